// File: rtl/w_align_stage.sv
// w_align_stage
//   Re-aligns a packed, byte-0-first store-data stream onto AXI W beats
//   whose first valid byte sits at the AW address offset. One descriptor
//   (offset, byte count) is queued per AW burst. A burst whose shifted
//   payload spills past its last input beat gets one extra FLUSH beat.
//
// Ports
//   clk_i, rst_ni                     clock, async active-low reset
//   desc_valid_i/desc_ready_o         descriptor handshake
//   desc_offset_i, desc_bytes_i       burst byte offset, payload bytes
//   w_data_i/w_valid_i/w_ready_o      packed input data stream
//   w_data_o/w_strb_o/w_last_o,
//   w_valid_o/w_ready_i               aligned AXI W output stream
module w_align_stage #(
    parameter int unsigned AxiDataWidth = 128,
    parameter int unsigned NumTrackers  = 8,
    parameter int unsigned LenWidth     = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              desc_valid_i,
    output logic                              desc_ready_o,
    input  logic [$clog2(AxiDataWidth/8)-1:0] desc_offset_i,
    input  logic [LenWidth-1:0]               desc_bytes_i,
    input  logic [AxiDataWidth-1:0]           w_data_i,
    input  logic                              w_valid_i,
    output logic                              w_ready_o,
    output logic [AxiDataWidth-1:0]           w_data_o,
    output logic [AxiDataWidth/8-1:0]         w_strb_o,
    output logic                              w_last_o,
    output logic                              w_valid_o,
    input  logic                              w_ready_i
);

    localparam int unsigned B     = AxiDataWidth / 8;
    localparam int unsigned OffW  = $clog2(B);
    localparam int unsigned PtrW  = $clog2(NumTrackers);
    localparam int unsigned CntPW = PtrW + 1;
    localparam int unsigned CntW  = LenWidth + 1;
    localparam int unsigned ShW   = OffW + 4;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

    // ---------------- descriptor FIFO ----------------
    logic [OffW-1:0]     r_fifo_off   [NumTrackers];
    logic [LenWidth-1:0] r_fifo_bytes [NumTrackers];
    logic [PtrW-1:0]     r_wr_ptr;
    logic [PtrW-1:0]     r_rd_ptr;
    logic [CntPW-1:0]    r_count;
    logic [PtrW-1:0]     w_rd_nxt;
    logic                w_push;
    logic                w_pop;

    assign desc_ready_o = (r_count != CntPW'(NumTrackers));
    assign w_push       = desc_valid_i && desc_ready_o;
    assign w_rd_nxt     = r_rd_ptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_off[r_wr_ptr]   <= desc_offset_i;
            r_fifo_bytes[r_wr_ptr] <= desc_bytes_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- burst datapath ----------------
    state_e              r_state;
    state_e              w_state_nxt;
    logic [OffW-1:0]     r_off;
    logic [LenWidth-1:0] r_bytes;
    logic [CntW-1:0]     r_in_beats;
    logic [CntW-1:0]     r_out_beats;
    logic [CntW-1:0]     r_k;
    logic [AxiDataWidth-1:0] r_prev;

    logic                w_load;
    logic                w_load_next;
    logic                w_done;
    logic [OffW-1:0]     w_ld_off;
    logic [LenWidth-1:0] w_ld_bytes;
    logic                w_in_hs;
    logic                w_last_in;
    logic                w_needs_flush;

    function automatic logic [CntW-1:0] ceil_beats(input logic [CntW-1:0] n);
        return (n + CntW'(B - 1)) >> OffW;
    endfunction

    // Chaining at end of burst loads the entry behind the one being popped.
    assign w_ld_off   = w_load_next ? r_fifo_off[w_rd_nxt]   : r_fifo_off[r_rd_ptr];
    assign w_ld_bytes = w_load_next ? r_fifo_bytes[w_rd_nxt] : r_fifo_bytes[r_rd_ptr];

    assign w_in_hs       = (r_state == STREAM) && w_valid_i && w_ready_i;
    assign w_last_in     = (r_k == r_in_beats - CntW'(1));
    assign w_needs_flush = (r_out_beats > r_in_beats);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_off       <= '0;
            r_bytes     <= '0;
            r_in_beats  <= '0;
            r_out_beats <= '0;
            r_k         <= '0;
            r_prev      <= '0;
        end else begin
            if (w_in_hs) begin
                r_prev <= w_data_i;
                r_k    <= r_k + 1'b1;
            end
            if (w_load) begin
                r_off       <= w_ld_off;
                r_bytes     <= w_ld_bytes;
                r_in_beats  <= ceil_beats(CntW'(w_ld_bytes));
                r_out_beats <= ceil_beats(CntW'(w_ld_off) + CntW'(w_ld_bytes));
                r_k         <= '0;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_load_next = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    if (r_fifo_bytes[r_rd_ptr] == '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                if (w_in_hs && w_last_in) begin
                    if (w_needs_flush) w_state_nxt = FLUSH;
                    else               w_done      = 1'b1;
                end
            end
            FLUSH: begin
                if (w_ready_i) w_done = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Burst complete: retire it and start the next non-empty one without a bubble.
        if (w_done) begin
            w_pop = 1'b1;
            if ((r_count > CntPW'(1)) && (r_fifo_bytes[w_rd_nxt] != '0)) begin
                w_load      = 1'b1;
                w_load_next = 1'b1;
                w_state_nxt = STREAM;
            end else begin
                w_state_nxt = IDLE;
            end
        end
    end

    // ---------------- output formation ----------------
    logic [AxiDataWidth-1:0] w_in_sel;
    logic [AxiDataWidth-1:0] w_aligned;
    logic [ShW-1:0]          w_shamt;
    logic [CntW-1:0]         w_base;
    logic [CntW-1:0]         w_lo;
    logic [CntW-1:0]         w_hi;
    logic [B-1:0]            w_strb;

    // {input, prev} shifted right by (B-off) bytes puts input byte 0 at lane off.
    assign w_in_sel  = (r_state == STREAM) ? w_data_i : '0;
    assign w_shamt   = (ShW'(B) - ShW'(r_off)) << 3;
    assign w_aligned = AxiDataWidth'({w_in_sel, r_prev} >> w_shamt);

    assign w_base = r_k << OffW;
    assign w_lo   = CntW'(r_off);
    assign w_hi   = CntW'(r_off) + CntW'(r_bytes);

    always_comb begin
        w_strb = '0;
        for (int unsigned b = 0; b < B; b++) begin
            w_strb[b] = ((w_base + CntW'(b)) >= w_lo) && ((w_base + CntW'(b)) < w_hi);
        end
    end

    always_comb begin
        w_valid_o = 1'b0;
        w_ready_o = 1'b0;
        w_last_o  = 1'b0;
        w_strb_o  = '0;
        w_data_o  = '0;
        case (r_state)
            STREAM: begin
                w_valid_o = w_valid_i;
                w_ready_o = w_ready_i;
                w_data_o  = w_aligned;
                w_strb_o  = w_strb;
                w_last_o  = w_last_in && !w_needs_flush;
            end
            FLUSH: begin
                w_valid_o = 1'b1;
                w_data_o  = w_aligned;
                w_strb_o  = w_strb;
                w_last_o  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_w_align_stage.sv
// tb_w_align_stage
//   Self-checking bench for w_align_stage (B = 16). Directed sequences
//   cover reset, flush beats, FIFO fill and reset during FLUSH; random
//   traffic is scored against a byte-address model of each burst.
`timescale 1ns/1ps
module tb_w_align_stage;

    localparam int unsigned DW = 128;
    localparam int unsigned B  = DW / 8;
    localparam int unsigned NT = 8;
    localparam int unsigned LW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          desc_valid_i;
    logic          desc_ready_o;
    logic [3:0]    desc_offset_i;
    logic [LW-1:0] desc_bytes_i;
    logic [DW-1:0] w_data_i;
    logic          w_valid_i;
    logic          w_ready_o;
    logic [DW-1:0] w_data_o;
    logic [B-1:0]  w_strb_o;
    logic          w_last_o;
    logic          w_valid_o;
    logic          w_ready_i;

    always #5 clk_i = ~clk_i;

    w_align_stage #(
        .AxiDataWidth(DW),
        .NumTrackers (NT),
        .LenWidth    (LW)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_offset_i(desc_offset_i),
        .desc_bytes_i (desc_bytes_i),
        .w_data_i     (w_data_i),
        .w_valid_i    (w_valid_i),
        .w_ready_o    (w_ready_o),
        .w_data_o     (w_data_o),
        .w_strb_o     (w_strb_o),
        .w_last_o     (w_last_o),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [DW-1:0] data; logic [B-1:0] strb; logic last; } beat_t;
    typedef struct { logic [3:0] off; logic [LW-1:0] bytes; } desc_t;

    desc_t         q_desc[$];
    logic [DW-1:0] q_in[$];
    beat_t         q_exp[$];

    // Payload byte p lands at burst address off+p; output beat i covers addresses i*B..i*B+B-1.
    task automatic plan_burst(input int unsigned off, input int unsigned nbytes);
        logic [7:0]    pl[];
        desc_t         d;
        beat_t         bt;
        logic [DW-1:0] beat;
        int unsigned   in_beats, out_beats, a;
        pl = new[nbytes];
        foreach (pl[i]) pl[i] = 8'($urandom);
        d.off   = 4'(off);
        d.bytes = LW'(nbytes);
        q_desc.push_back(d);
        in_beats = (nbytes + B - 1) / B;
        for (int unsigned i = 0; i < in_beats; i++) begin
            for (int unsigned j = 0; j < B; j++) begin
                a = i * B + j;
                beat[j*8 +: 8] = (a < nbytes) ? pl[a] : 8'($urandom);
            end
            q_in.push_back(beat);
        end
        out_beats = (nbytes == 0) ? 0 : (off + nbytes + B - 1) / B;
        for (int unsigned i = 0; i < out_beats; i++) begin
            bt.data = '0;
            bt.strb = '0;
            bt.last = (i == out_beats - 1);
            for (int unsigned j = 0; j < B; j++) begin
                a = i * B + j;
                if (a >= off && a < off + nbytes) begin
                    bt.strb[j]      = 1'b1;
                    bt.data[j*8 +: 8] = pl[a - off];
                end
            end
            q_exp.push_back(bt);
        end
    endtask

    // Called and returns at posedge+1. Percentages control valid/ready duty.
    task automatic run_traffic(input int unsigned p_desc, input int unsigned p_in,
                               input int unsigned p_out, input int unsigned budget);
        int unsigned   cyc = 0;
        bit            in_held = 1'b0;
        bit            desc_acc, in_acc;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data, mask;
        logic [B-1:0]  prev_strb;
        logic          prev_last;
        while ((q_desc.size() + q_in.size() + q_exp.size() > 0) && cyc < budget) begin
            desc_valid_i = (q_desc.size() > 0) && ($urandom_range(99) < p_desc);
            if (q_desc.size() > 0) begin
                desc_offset_i = q_desc[0].off;
                desc_bytes_i  = q_desc[0].bytes;
            end
            if (!in_held) begin
                w_valid_i = (q_in.size() > 0) && ($urandom_range(99) < p_in);
                if (q_in.size() > 0) w_data_i = q_in[0];
            end
            w_ready_i = ($urandom_range(99) < p_out);
            @(negedge clk_i);
            desc_acc = desc_valid_i && desc_ready_o;
            in_acc   = w_valid_i && w_ready_o;
            if (prev_stall) begin
                check_eq("hold_valid", DW'(w_valid_o), DW'(1'b1));
                check_eq("hold_data",  w_data_o, prev_data);
                check_eq("hold_strb",  DW'(w_strb_o), DW'(prev_strb));
                check_eq("hold_last",  DW'(w_last_o), DW'(prev_last));
            end
            if (q_exp.size() == 0) begin
                check_eq("spurious_beat", DW'(w_valid_o), '0);
            end else if (w_valid_o && w_ready_i) begin
                for (int unsigned j = 0; j < B; j++) mask[j*8 +: 8] = {8{q_exp[0].strb[j]}};
                check_eq("beat_strb", DW'(w_strb_o), DW'(q_exp[0].strb));
                check_eq("beat_data", w_data_o & mask, q_exp[0].data);
                check_eq("beat_last", DW'(w_last_o), DW'(q_exp[0].last));
                void'(q_exp.pop_front());
            end
            prev_stall = w_valid_o && !w_ready_i;
            prev_data  = w_data_o;
            prev_strb  = w_strb_o;
            prev_last  = w_last_o;
            @(posedge clk_i); #1;
            if (desc_acc) void'(q_desc.pop_front());
            if (in_acc)   void'(q_in.pop_front());
            in_held = w_valid_i && !in_acc;
            cyc++;
        end
        check_eq("traffic_drained", DW'(q_desc.size() + q_in.size() + q_exp.size()), '0);
        desc_valid_i = 1'b0;
        w_valid_i    = 1'b0;
    endtask

    task automatic push_desc(input int unsigned off, input int unsigned nbytes);
        desc_valid_i  = 1'b1;
        desc_offset_i = 4'(off);
        desc_bytes_i  = LW'(nbytes);
        @(posedge clk_i); #1;
        desc_valid_i = 1'b0;
    endtask

    logic [DW-1:0] d0;
    int unsigned   rb;

    initial begin
        rst_ni        = 1'b0;
        desc_valid_i  = 1'b0;
        desc_offset_i = '0;
        desc_bytes_i  = '0;
        w_data_i      = '0;
        w_valid_i     = 1'b0;
        w_ready_i     = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_desc_ready", DW'(desc_ready_o), DW'(1'b1));
        check_eq("rst_w_ready",    DW'(w_ready_o), '0);
        check_eq("rst_w_valid",    DW'(w_valid_o), '0);
        check_eq("rst_w_last",     DW'(w_last_o), '0);
        check_eq("rst_w_strb",     DW'(w_strb_o), '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_eq("post_rst_w_valid", DW'(w_valid_o), '0);
        @(posedge clk_i); #1;

        // Aligned two-beat burst passes through
        plan_burst(0, 32);
        run_traffic(100, 100, 100, 200);

        // off=4, 16 bytes: shifted beat then FLUSH beat
        push_desc(4, 16);
        @(posedge clk_i); #1;
        d0 = {$urandom, $urandom, $urandom, $urandom};
        w_data_i = d0; w_valid_i = 1'b1; w_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("o4_b0_valid", DW'(w_valid_o), DW'(1'b1));
        check_eq("o4_b0_ready", DW'(w_ready_o), DW'(1'b1));
        check_eq("o4_b0_strb",  DW'(w_strb_o), DW'(16'hFFF0));
        check_eq("o4_b0_data",  DW'(w_data_o[DW-1:32]), DW'(d0[95:0]));
        check_eq("o4_b0_last",  DW'(w_last_o), '0);
        @(posedge clk_i); #1;
        w_valid_i = 1'b0; w_data_i = ~d0;
        @(negedge clk_i);
        check_eq("o4_fl_valid", DW'(w_valid_o), DW'(1'b1));
        check_eq("o4_fl_ready", DW'(w_ready_o), '0);
        check_eq("o4_fl_strb",  DW'(w_strb_o), DW'(16'h000F));
        check_eq("o4_fl_data",  DW'(w_data_o[31:0]), DW'(d0[127:96]));
        check_eq("o4_fl_last",  DW'(w_last_o), DW'(1'b1));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("o4_idle_valid", DW'(w_valid_o), '0);
        @(posedge clk_i); #1;

        // off=12, 8 bytes; FLUSH held by w_ready_i low, then reset inside FLUSH
        push_desc(12, 8);
        @(posedge clk_i); #1;
        d0 = {$urandom, $urandom, $urandom, $urandom};
        w_data_i = d0; w_valid_i = 1'b1; w_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("o12_b0_strb", DW'(w_strb_o), DW'(16'hF000));
        check_eq("o12_b0_data", DW'(w_data_o[127:96]), DW'(d0[31:0]));
        check_eq("o12_b0_last", DW'(w_last_o), '0);
        @(posedge clk_i); #1;
        w_valid_i = 1'b0; w_ready_i = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq($sformatf("o12_fl_valid_%0d", i), DW'(w_valid_o), DW'(1'b1));
            check_eq($sformatf("o12_fl_ready_%0d", i), DW'(w_ready_o), '0);
            check_eq($sformatf("o12_fl_strb_%0d", i),  DW'(w_strb_o), DW'(16'h000F));
            check_eq($sformatf("o12_fl_data_%0d", i),  DW'(w_data_o[31:0]), DW'(d0[63:32]));
            check_eq($sformatf("o12_fl_last_%0d", i),  DW'(w_last_o), DW'(1'b1));
            @(posedge clk_i); #1;
        end
        rst_ni = 1'b0;
        #1;
        check_eq("rstfl_valid",      DW'(w_valid_o), '0);
        check_eq("rstfl_strb",       DW'(w_strb_o), '0);
        check_eq("rstfl_desc_ready", DW'(desc_ready_o), DW'(1'b1));
        @(posedge clk_i); #1;
        rst_ni    = 1'b1;
        w_valid_i = 1'b1; w_ready_i = 1'b1;
        w_data_i  = {$urandom, $urandom, $urandom, $urandom};
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq($sformatf("after_rst_valid_%0d", i), DW'(w_valid_o), '0);
            check_eq($sformatf("after_rst_ready_%0d", i), DW'(w_ready_o), '0);
            @(posedge clk_i); #1;
        end
        w_valid_i = 1'b0;

        // Fill the descriptor FIFO, try a 9th push, then drain back-to-back
        for (int unsigned i = 0; i < NT; i++) begin
            check_eq($sformatf("fill_ready_%0d", i), DW'(desc_ready_o), DW'(1'b1));
            push_desc(0, 16);
        end
        check_eq("fill_full", DW'(desc_ready_o), '0);
        desc_valid_i = 1'b1; desc_offset_i = '0; desc_bytes_i = LW'(16);
        @(posedge clk_i); #1;
        check_eq("fill_ninth_blocked", DW'(desc_ready_o), '0);
        desc_valid_i = 1'b0;
        for (int unsigned i = 0; i < NT; i++) begin
            d0 = {$urandom, $urandom, $urandom, $urandom};
            w_data_i = d0; w_valid_i = 1'b1; w_ready_i = 1'b1;
            @(negedge clk_i);
            check_eq($sformatf("b2b_valid_%0d", i), DW'(w_valid_o), DW'(1'b1));
            check_eq($sformatf("b2b_last_%0d", i),  DW'(w_last_o), DW'(1'b1));
            check_eq($sformatf("b2b_data_%0d", i),  w_data_o, d0);
            check_eq($sformatf("b2b_strb_%0d", i),  DW'(w_strb_o), DW'(16'hFFFF));
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check_eq("b2b_empty_valid", DW'(w_valid_o), '0);
        check_eq("b2b_empty_ready", DW'(w_ready_o), '0);
        check_eq("b2b_desc_ready",  DW'(desc_ready_o), DW'(1'b1));
        @(posedge clk_i); #1;
        w_valid_i = 1'b0;

        // Random traffic with backpressure, then at full throughput
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned n = 0; n < 40; n++) begin
                rb = $urandom_range(9);
                if (rb == 0)      plan_burst($urandom_range(15), 0);
                else if (rb == 1) plan_burst($urandom_range(15), B * $urandom_range(1, 4));
                else              plan_burst($urandom_range(15), $urandom_range(1, 70));
            end
            if (pass == 0) run_traffic(50, 70, 60, 20000);
            else           run_traffic(100, 100, 100, 20000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
